// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing constants and helpers. Holds the default 640x480@60 timing
// (active / front porch / sync / back porch / total for both axes) plus the
// derived sync window bounds, so the timing generator and the downstream
// pixel/colour stage agree on one set of numbers.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int CNT_W = 10;   // x / y counter width
    localparam int DIV_W = 4;    // pixel clock divider width

    typedef logic [CNT_W-1:0] coord_t;

    // Axis length in pixels (H) or lines (V).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First count value inside the sync pulse.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // First count value after the sync pulse (exclusive bound).
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    // lo <= c < hi
    function automatic logic in_window(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_FP         = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BP         = 48;
    localparam int VGA_H_TOTAL      = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_H_SYNC_START = sync_start(VGA_H_ACTIVE, VGA_H_FP);
    localparam int VGA_H_SYNC_END   = sync_end(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC);

    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_FP         = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BP         = 33;
    localparam int VGA_V_TOTAL      = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
    localparam int VGA_V_SYNC_START = sync_start(VGA_V_ACTIVE, VGA_V_FP);
    localparam int VGA_V_SYNC_END   = sync_end(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of timing outputs produced by vga_timing_gen.
//   pix_tick    one-clk pulse per pixel advance
//   x, y        pixel / line counters
//   hsync/vsync active-low sync pulses
//   inrect      active video area
//   borders     low on the active-area edge pixels
//   line_start  pulse when x wraps to 0
//   frame_start pulse when x and y both wrap to 0
// master: the timing generator; slave: consumers.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic   pix_tick;
    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   inrect;
    logic   borders;
    logic   line_start;
    logic   frame_start;

    modport master (
        output pix_tick, x, y, hsync, vsync, inrect, borders, line_start, frame_start
    );

    modport slave (
        input pix_tick, x, y, hsync, vsync, inrect, borders, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical): a wrapping counter with a
// registered active-low sync output. Decodes are taken from the next-state
// count so every registered flag lines up with the count it describes.
//   clk, rst_n   clock, async active-low reset
//   adv_i        advance the count this clk
//   wrap_o       adv_i while the count sits at its last value (comb)
//   active_d_o   next count lies in the active region (comb)
//   edge_d_o     next count is the first or last active position (comb)
//   count_o      registered count
//   sync_n_o     registered active-low sync
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   adv_i,
    output logic   wrap_o,
    output logic   active_d_o,
    output logic   edge_d_o,
    output coord_t count_o,
    output logic   sync_n_o
);

    localparam int     TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam coord_t LAST  = coord_t'(TOTAL - 1);
    localparam coord_t ALAST = coord_t'(ACTIVE - 1);

    coord_t count_q, count_d;
    logic   sync_n_q, sync_n_d;
    logic   wrap;

    always_comb begin
        wrap     = adv_i && (count_q == LAST);
        count_d  = count_q;
        if (adv_i) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        sync_n_d   = !in_window(count_d, sync_start(ACTIVE, FP), sync_end(ACTIVE, FP, SYNC));
        active_d_o = in_window(count_d, 0, ACTIVE);
        edge_d_o   = (count_d == '0) || (count_d == ALAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign wrap_o   = wrap;
    assign count_o  = count_q;
    assign sync_n_o = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator. A clock divider produces the pixel advance;
// a horizontal axis counter advances on it and a vertical axis counter
// advances on each horizontal wrap. All outputs are registers fed from
// next-state values, so sync/inrect/borders never lag x/y.
//   clk    system clock
//   rst_n  async active-low reset
//   en     run enable; low freezes counters/levels and suppresses pulses
//   vga    timing outputs (vga_timing_gen_if master)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    vga_timing_gen_if.master vga
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_d;
    logic             pix_tick_q, line_start_q, frame_start_q;
    logic             inrect_q, inrect_d;
    logic             borders_q, borders_d;

    logic   h_wrap, h_active_d, h_edge_d, h_sync_n;
    logic   v_wrap, v_active_d, v_edge_d, v_sync_n;
    coord_t h_count, v_count;

    // With CLK_DIV=1 DIV_LAST is 0, so div stays 0 and tick follows en.
    always_comb begin
        tick_d = en && (div_q == DIV_LAST);
        div_d  = div_q;
        if (en) begin
            div_d = tick_d ? '0 : div_q + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (tick_d),
        .wrap_o     (h_wrap),
        .active_d_o (h_active_d),
        .edge_d_o   (h_edge_d),
        .count_o    (h_count),
        .sync_n_o   (h_sync_n)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (h_wrap),
        .wrap_o     (v_wrap),
        .active_d_o (v_active_d),
        .edge_d_o   (v_edge_d),
        .count_o    (v_count),
        .sync_n_o   (v_sync_n)
    );

    // Border is only meaningful inside the active rectangle; outside it is high.
    always_comb begin
        inrect_d  = h_active_d && v_active_d;
        borders_d = !(inrect_d && (h_edge_d || v_edge_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            inrect_q      <= 1'b1;
            borders_q     <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= tick_d;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
            inrect_q      <= inrect_d;
            borders_q     <= borders_d;
        end
    end

    assign vga.pix_tick    = pix_tick_q;
    assign vga.x           = h_count;
    assign vga.y           = v_count;
    assign vga.hsync       = h_sync_n;
    assign vga.vsync       = v_sync_n;
    assign vga.inrect      = inrect_q;
    assign vga.borders     = borders_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generator instances (default 640x480 with CLK_DIV=2, a small raster
// with CLK_DIV=3, a tiny raster with CLK_DIV=1) share clk/rst_n/en. Each is
// compared every clk against an arithmetic model: the number of enabled
// clocks since reset determines the pixel index, and x/y/sync/etc. follow
// from division and range tests.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if vga_a ();
    vga_timing_gen_if vga_b ();
    vga_timing_gen_if vga_c ();

    vga_timing_gen #(.CLK_DIV(2)) dut_a (
        .clk (clk), .rst_n (rst_n), .en (en), .vga (vga_a)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .en (en), .vga (vga_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_c (
        .clk (clk), .rst_n (rst_n), .en (en), .vga (vga_c)
    );

    typedef struct {
        int cdiv;
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
    } cfg_t;

    typedef struct packed {
        logic pt;
        int   x;
        int   y;
        logic hs, vs, inr, bd, ls, fs;
    } obs_t;

    typedef struct {
        int e, x, y, pt, hs, vs, inr, bd, ls;
    } vec_t;

    cfg_t cfgs[3];
    int   checks   = 0;
    int   failures = 0;
    int   ecount   = 0;   // enabled clk edges since reset
    bit   last_en  = 1'b0;

    function automatic obs_t model(input cfg_t c, input int e, input bit len);
        obs_t r;
        int ht, vt, p;
        ht   = c.ha + c.hf + c.hs + c.hb;
        vt   = c.va + c.vf + c.vs + c.vb;
        p    = (e / c.cdiv) % (ht * vt);
        r.x  = p % ht;
        r.y  = p / ht;
        r.pt = len && (e > 0) && (e % c.cdiv == 0);
        r.hs = !(r.x >= c.ha + c.hf && r.x < c.ha + c.hf + c.hs);
        r.vs = !(r.y >= c.va + c.vf && r.y < c.va + c.vf + c.vs);
        r.inr = (r.x < c.ha) && (r.y < c.va);
        r.bd = !(r.inr && (r.x == 0 || r.x == c.ha - 1 || r.y == 0 || r.y == c.va - 1));
        r.ls = r.pt && (r.x == 0);
        r.fs = r.ls && (r.y == 0);
        return r;
    endfunction

    function automatic obs_t mk(input logic pt, input coord_t x, input coord_t y,
                                input logic hs, input logic vs, input logic inr,
                                input logic bd, input logic ls, input logic fs);
        obs_t r;
        r.pt = pt; r.x = int'(x); r.y = int'(y);
        r.hs = hs; r.vs = vs; r.inr = inr; r.bd = bd; r.ls = ls; r.fs = fs;
        return r;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s e=%0d: got x=%0d y=%0d pt=%b hs=%b vs=%b in=%b bd=%b ls=%b fs=%b, required x=%0d y=%0d pt=%b hs=%b vs=%b in=%b bd=%b ls=%b fs=%b",
                     name, ecount, act.x, act.y, act.pt, act.hs, act.vs, act.inr, act.bd, act.ls, act.fs,
                     exp.x, exp.y, exp.pt, exp.hs, exp.vs, exp.inr, exp.bd, exp.ls, exp.fs);
        end
    endtask

    task automatic check_all(input string tag);
        check_obs({tag, "/A"}, mk(vga_a.pix_tick, vga_a.x, vga_a.y, vga_a.hsync, vga_a.vsync,
                  vga_a.inrect, vga_a.borders, vga_a.line_start, vga_a.frame_start),
                  model(cfgs[0], ecount, last_en));
        check_obs({tag, "/B"}, mk(vga_b.pix_tick, vga_b.x, vga_b.y, vga_b.hsync, vga_b.vsync,
                  vga_b.inrect, vga_b.borders, vga_b.line_start, vga_b.frame_start),
                  model(cfgs[1], ecount, last_en));
        check_obs({tag, "/C"}, mk(vga_c.pix_tick, vga_c.x, vga_c.y, vga_c.hsync, vga_c.vsync,
                  vga_c.inrect, vga_c.borders, vga_c.line_start, vga_c.frame_start),
                  model(cfgs[2], ecount, last_en));
    endtask

    // One clk: update the enabled-edge count at the rising edge, compare on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) ecount = 0;
        else if (en) ecount++;
        last_en = en;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int first_b, second_b, lines_b, first_c, second_c, lines_c, cyc;

        cfgs[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        cfgs[1] = '{3, 10, 2, 3, 1, 6, 1, 2, 2};
        cfgs[2] = '{1, 4, 1, 1, 1, 3, 1, 1, 1};

        //              e     x    y  pt hs vs in bd ls
        vecs.push_back('{0,    0,   0, 0, 1, 1, 1, 0, 0});
        vecs.push_back('{1,    0,   0, 0, 1, 1, 1, 0, 0});
        vecs.push_back('{2,    1,   0, 1, 1, 1, 1, 0, 0});
        vecs.push_back('{1278, 639, 0, 1, 1, 1, 1, 0, 0});
        vecs.push_back('{1280, 640, 0, 1, 1, 1, 0, 1, 0});
        vecs.push_back('{1310, 655, 0, 1, 1, 1, 0, 1, 0});
        vecs.push_back('{1312, 656, 0, 1, 0, 1, 0, 1, 0});
        vecs.push_back('{1502, 751, 0, 1, 0, 1, 0, 1, 0});
        vecs.push_back('{1504, 752, 0, 1, 1, 1, 0, 1, 0});
        vecs.push_back('{1598, 799, 0, 1, 1, 1, 0, 1, 0});
        vecs.push_back('{1599, 799, 0, 0, 1, 1, 0, 1, 0});
        vecs.push_back('{1600, 0,   1, 1, 1, 1, 1, 0, 1});
        vecs.push_back('{1602, 1,   1, 1, 1, 1, 1, 1, 0});
        vecs.push_back('{1920, 160, 1, 1, 1, 1, 1, 1, 0});
        vecs.push_back('{2878, 639, 1, 1, 1, 1, 1, 0, 0});
        vecs.push_back('{3200, 0,   2, 1, 1, 1, 1, 0, 1});

        // Held in reset with en high: nothing may move.
        en = 1'b1;
        repeat (3) step("reset_hold");

        // Release on a falling edge; the table walks the default DUT from there.
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            while (ecount < vecs[i].e) step("table_run");
            checks++;
            if (int'(vga_a.x) != vecs[i].x || int'(vga_a.y) != vecs[i].y ||
                int'(vga_a.pix_tick) != vecs[i].pt || int'(vga_a.hsync) != vecs[i].hs ||
                int'(vga_a.vsync) != vecs[i].vs || int'(vga_a.inrect) != vecs[i].inr ||
                int'(vga_a.borders) != vecs[i].bd || int'(vga_a.line_start) != vecs[i].ls) begin
                failures++;
                $display("FAIL vec%0d e=%0d: got x=%0d y=%0d pt=%b hs=%b vs=%b in=%b bd=%b ls=%b, required x=%0d y=%0d pt=%0d hs=%0d vs=%0d in=%0d bd=%0d ls=%0d",
                         i, ecount, vga_a.x, vga_a.y, vga_a.pix_tick, vga_a.hsync, vga_a.vsync,
                         vga_a.inrect, vga_a.borders, vga_a.line_start,
                         vecs[i].x, vecs[i].y, vecs[i].pt, vecs[i].hs, vecs[i].vs,
                         vecs[i].inr, vecs[i].bd, vecs[i].ls);
            end
        end

        // Freeze at x=100, y=5 for 50 clks, then resume.
        while (ecount < 2 * (5 * 800 + 100)) step("to_freeze");
        check_int("freeze_x_start", int'(vga_a.x), 100);
        check_int("freeze_y_start", int'(vga_a.y), 5);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step("frozen");
            check_int("frozen_state",
                      int'({vga_a.x, vga_a.y, vga_a.hsync, vga_a.vsync, vga_a.pix_tick,
                            vga_a.line_start, vga_a.frame_start}),
                      int'({10'd100, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        end
        en = 1'b1;
        step("resume");
        step("resume");
        check_int("resume_x", int'(vga_a.x), 101);
        check_int("resume_tick", int'(vga_a.pix_tick), 1);

        // Frame period and line_start count on the two small rasters.
        first_b = -1; second_b = -1; lines_b = 0;
        first_c = -1; second_c = -1; lines_c = 0;
        cyc = 0;
        for (int i = 0; i < 1700 && (second_b < 0 || second_c < 0); i++) begin
            step("frame");
            cyc++;
            if (vga_b.line_start && first_b >= 0 && second_b < 0) lines_b++;
            if (vga_c.line_start && first_c >= 0 && second_c < 0) lines_c++;
            if (vga_b.frame_start) begin
                if (first_b < 0) first_b = cyc;
                else if (second_b < 0) second_b = cyc;
            end
            if (vga_c.frame_start) begin
                if (first_c < 0) first_c = cyc;
                else if (second_c < 0) second_c = cyc;
            end
        end
        check_int("frame_period_B", second_b - first_b, 16 * 11 * 3);
        check_int("lines_per_frame_B", lines_b, 11);
        check_int("frame_period_C", second_c - first_c, 7 * 6 * 1);
        check_int("lines_per_frame_C", lines_c, 6);

        // Random enable pattern against the model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step("random");
        end

        // Fresh reset, run to x=700 y=1 (inside hsync), then reset between edges.
        rst_n = 1'b0;
        en = 1'b1;
        step("rereset");
        rst_n = 1'b1;
        while (ecount < 2 * (800 + 700)) step("to_async");
        check_int("pre_async_x", int'(vga_a.x), 700);
        check_int("pre_async_hsync", int'(vga_a.hsync), 0);
        #2;
        rst_n = 1'b0;
        #1;
        ecount = 0;
        check_all("async_reset");
        check_int("async_state",
                  int'({vga_a.x, vga_a.y, vga_a.hsync, vga_a.vsync, vga_a.inrect,
                        vga_a.borders, vga_a.pix_tick, vga_a.line_start, vga_a.frame_start}),
                  int'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
